design_seq_arbiter: RTL and testbench
=====================================

DESIGN_SEQ_ARBITER -- requirements
Module: design_seq_arbiter

Interface
REQ-001 Parameter W, 11, operand/result width.
REQ-002 Parameter WAIT_LIMIT, 16, max cycles in WAIT before timeout (1..255).
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 reqN_valid  in  1  requester N (N=0,1) has a transaction.
REQ-006 reqN_sta, reqN_stb, reqN_key  in  W each  operands; key feeds both result_stc_1 and check_std_1.
REQ-007 reqN_ready  out  1  transaction from N accepted this cycle.
REQ-008 start_sta_1, start_stb_1, result_stc_1, check_std_1  out  W each  operands to design.
REQ-009 EN_start, EN_check  out  1  method enables; RDY_start, RDY_result, RDY_check  in  1  method readies.
REQ-010 result, check  in  W  design value outputs.
REQ-011 rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  1; rsp_err  out  1; rsp_result, rsp_check  out  W.

Function
REQ-012 FSM states IDLE, ISSUE, WAIT, CHECK, RESP; reset state IDLE.
REQ-013 IDLE: if any reqN_valid, assert reqN_ready for the winner only (combinational), latch sta/stb/key and id, go ISSUE.
REQ-014 Arbitration round-robin: both valid -> grant requester != last_grant; one valid -> grant it; last_grant resets to 1 (req0 first).
REQ-015 reqN_ready SHALL be 0 in all states except IDLE.
REQ-016 ISSUE: EN_start = RDY_start; on RDY_start=1 go WAIT, clear wait counter; else stay.
REQ-017 WAIT: if RDY_result=1, register result, go CHECK; else increment 8-bit counter; if counter reaches WAIT_LIMIT-1 with RDY_result=0, set err, go RESP.
REQ-018 CHECK: EN_check = RDY_check; on RDY_check=1 register check in same cycle, go RESP.
REQ-019 RESP: rsp_valid=1, fields stable until rsp_ready=1; on handshake update last_grant to served id, go IDLE.
REQ-020 Timeout response: rsp_err=1, rsp_result=0, rsp_check=0; EN_check never asserted.
REQ-021 Operand outputs always drive latched values; EN_start/EN_check 0 outside ISSUE/CHECK.
REQ-022 Minimum latency: accept at edge T -> rsp_valid at T+4 when all RDY_* high.
REQ-023 New request not accepted in RESP-handshake cycle; earliest accept is next cycle (one-cycle bubble).
REQ-024 At most one transaction outstanding.

Reset
REQ-025 RST=1 forces immediately: state IDLE, last_grant=1, latched operands/results/err/counter 0, all outputs 0.
REQ-026 Reset mid-transaction drops it silently; no response issued, no EN_* pulse after reset.

Structure
REQ-027 Shared package: W, state enum, requester-id type, response struct.
REQ-028 One sub-module rr_arbiter_2 (2-way round-robin grant from valids and last_grant); FSM and datapath in top.

Verification
REQ-029 Single req0 sta=0x005 stb=0x003 key=0x001, all RDY high, result=0x008 check=0x001 -> one EN_start pulse with operands, rsp_valid at T+4, id=0, result=0x008, err=0.
REQ-030 req0 and req1 valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 over 4 transactions.
REQ-031 RDY_start low 3 cycles then high -> EN_start only in cycle RDY_start=1; rsp_valid at T+7.
REQ-032 RDY_result held low, WAIT_LIMIT=16 -> rsp_valid with err=1, result=0, no EN_check pulse.
REQ-033 rsp_ready low 5 cycles in RESP -> rsp fields stable, reqN_ready stays 0, accept resumes cycle after handshake.
REQ-034 RST asserted during WAIT -> outputs 0 at once; after release, fresh req1 serviced with no stale response.

Source files
------------

// File: rtl/design_seq_arbiter_pkg.sv
// Shared types and constants for the sequenced two-requester arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: default data width, FSM state enum, requester id type, response record.
package design_seq_arbiter_pkg;

  localparam int DATA_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Requester index: 0 or 1.
  typedef logic id_t;

  // Everything presented on the response channel, held in one register.
  typedef struct packed {
    logic              err;
    id_t               id;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] check;
  } rsp_t;

endpackage

// File: rtl/design_seq_arbiter_if.sv
// Bundle of request, downstream-method and response signals of the arbiter.
// Latency: n/a (wires only).
// Backpressure: reqN_valid/reqN_ready and rsp_valid/rsp_ready handshakes; RDY_* gate EN_*.
// Modports: master = requesters + downstream design + response sink; slave = arbiter.
interface design_seq_arbiter_if
  import design_seq_arbiter_pkg::*;
#(
  parameter int W = DATA_W
) ();

  // Requester 0
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_sta;
  logic [W-1:0] req0_stb;
  logic [W-1:0] req0_key;
  // Requester 1
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_sta;
  logic [W-1:0] req1_stb;
  logic [W-1:0] req1_key;
  // Downstream design methods
  logic [W-1:0] start_sta_1;
  logic [W-1:0] start_stb_1;
  logic [W-1:0] result_stc_1;
  logic [W-1:0] check_std_1;
  logic         EN_start;
  logic         EN_check;
  logic         RDY_start;
  logic         RDY_result;
  logic         RDY_check;
  logic [W-1:0] result;
  logic [W-1:0] check;
  // Response channel
  logic         rsp_valid;
  logic         rsp_ready;
  id_t          rsp_id;
  logic         rsp_err;
  logic [W-1:0] rsp_result;
  logic [W-1:0] rsp_check;

  modport master (
    output req0_valid, req0_sta, req0_stb, req0_key,
    output req1_valid, req1_sta, req1_stb, req1_key,
    input  req0_ready, req1_ready,
    input  start_sta_1, start_stb_1, result_stc_1, check_std_1, EN_start, EN_check,
    output RDY_start, RDY_result, RDY_check, result, check,
    input  rsp_valid, rsp_id, rsp_err, rsp_result, rsp_check,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_sta, req0_stb, req0_key,
    input  req1_valid, req1_sta, req1_stb, req1_key,
    output req0_ready, req1_ready,
    output start_sta_1, start_stb_1, result_stc_1, check_std_1, EN_start, EN_check,
    input  RDY_start, RDY_result, RDY_check, result, check,
    output rsp_valid, rsp_id, rsp_err, rsp_result, rsp_check,
    input  rsp_ready
  );

endinterface

// File: rtl/design_seq_arbiter_rr_arbiter_2.sv
// Two-way round-robin grant selection.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is consumed.
// Ports: valid[1:0] in, last_grant in, grant_vld out, grant_id out.
module rr_arbiter_2
  import design_seq_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  id_t        last_grant,
  output logic       grant_vld,
  output id_t        grant_id
);

  always_comb begin
    grant_vld = |valid;
    grant_id  = 1'b0;
    if (&valid) begin
      // Contention: favour whoever was not served last.
      grant_id = ~last_grant;
    end else if (valid[1]) begin
      grant_id = 1'b1;
    end
  end

endmodule

// File: rtl/design_seq_arbiter.sv
// Arbitrates two requesters onto a start/result/check design and returns one response.
// Latency: accept cycle + ISSUE + WAIT + CHECK, response at accept edge +4 minimum.
// Backpressure: RDY_* stall ISSUE/WAIT/CHECK; rsp_ready holds RESP; one transaction outstanding.
// Ports: clk, rst (async active-high), bus (slave modport of design_seq_arbiter_if).
module design_seq_arbiter
  import design_seq_arbiter_pkg::*;
#(
  parameter int W          = DATA_W,
  parameter int WAIT_LIMIT = 16
) (
  input logic                 clk,
  input logic                 rst,
  design_seq_arbiter_if.slave bus
);

  state_t       state_q, state_d;
  id_t          last_grant_q, last_grant_d;
  logic [W-1:0] sta_q, sta_d;
  logic [W-1:0] stb_q, stb_d;
  logic [W-1:0] key_q, key_d;
  rsp_t         rsp_q, rsp_d;
  logic [7:0]   cnt_q, cnt_d;

  logic         grant_vld;
  id_t          grant_id;
  logic         req0_ready_c;
  logic         req1_ready_c;
  logic         en_start_c;
  logic         en_check_c;
  logic         rsp_valid_c;

  rr_arbiter_2 u_rr (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant_q),
    .grant_vld  (grant_vld),
    .grant_id   (grant_id)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sta_d        = sta_q;
    stb_d        = stb_q;
    key_d        = key_q;
    rsp_d        = rsp_q;
    cnt_d        = cnt_q;
    req0_ready_c = 1'b0;
    req1_ready_c = 1'b0;
    en_start_c   = 1'b0;
    en_check_c   = 1'b0;
    rsp_valid_c  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          req0_ready_c = (grant_id == 1'b0);
          req1_ready_c = (grant_id == 1'b1);
          sta_d        = grant_id ? bus.req1_sta : bus.req0_sta;
          stb_d        = grant_id ? bus.req1_stb : bus.req0_stb;
          key_d        = grant_id ? bus.req1_key : bus.req0_key;
          // Fresh response record: a timeout leaves result/check at zero.
          rsp_d        = '0;
          rsp_d.id     = grant_id;
          cnt_d        = '0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        en_start_c = bus.RDY_start;
        if (bus.RDY_start) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.RDY_result) begin
          rsp_d.result = bus.result;
          state_d      = ST_CHECK;
        end else if (cnt_q == 8'(WAIT_LIMIT - 1)) begin
          // Last allowed WAIT cycle elapsed without a result.
          rsp_d.err = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_CHECK: begin
        en_check_c = bus.RDY_check;
        if (bus.RDY_check) begin
          rsp_d.check = bus.check;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) begin
          last_grant_d = rsp_q.id;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      sta_q        <= '0;
      stb_q        <= '0;
      key_q        <= '0;
      rsp_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sta_q        <= sta_d;
      stb_q        <= stb_d;
      key_q        <= key_d;
      rsp_q        <= rsp_d;
      cnt_q        <= cnt_d;
    end
  end

  // Ready is combinational from the request valids, so it is masked while
  // reset is held to keep every output at zero during reset.
  assign bus.req0_ready   = req0_ready_c & ~rst;
  assign bus.req1_ready   = req1_ready_c & ~rst;
  assign bus.start_sta_1  = sta_q;
  assign bus.start_stb_1  = stb_q;
  assign bus.result_stc_1 = key_q;
  assign bus.check_std_1  = key_q;
  assign bus.EN_start     = en_start_c;
  assign bus.EN_check     = en_check_c;
  assign bus.rsp_valid    = rsp_valid_c;
  assign bus.rsp_id       = rsp_q.id;
  assign bus.rsp_err      = rsp_q.err;
  assign bus.rsp_result   = rsp_q.result;
  assign bus.rsp_check    = rsp_q.check;

endmodule

// File: tb/tb_design_seq_arbiter.sv
module tb_design_seq_arbiter;

  localparam int W = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  design_seq_arbiter_if #(.W(W)) bus ();

  design_seq_arbiter #(.W(W), .WAIT_LIMIT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Samples each cycle until rsp_valid; records EN pulses and operands seen with EN_start.
  task automatic wait_rsp(input int start_lat, input int budget, output int lat,
                          output int n_start, output int n_check,
                          output logic [W-1:0] s_sta, output logic [W-1:0] s_stb,
                          output logic [W-1:0] s_key, output bit timed_out);
    lat = start_lat; n_start = 0; n_check = 0; timed_out = 1'b1;
    s_sta = '0; s_stb = '0; s_key = '0;
    #1;
    for (int i = 0; i < budget; i++) begin
      if (bus.rsp_valid === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      if (bus.EN_start === 1'b1) begin
        n_start++;
        s_sta = bus.start_sta_1; s_stb = bus.start_stb_1; s_key = bus.result_stc_1;
      end
      if (bus.EN_check === 1'b1) n_check++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bus.req0_sta = 11'h7AA; bus.req0_stb = 11'h055; bus.req0_key = 11'h0F0;
    bus.req1_sta = 11'h0AA; bus.req1_stb = 11'h155; bus.req1_key = 11'h00F;
    bus.RDY_start = 1'b1; bus.RDY_result = 1'b1; bus.RDY_check = 1'b1;
    bus.result = 11'h3FF; bus.check = 11'h3FF; bus.rsp_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got %b want 0", bus.req0_ready); end
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready got %b want 0", bus.req1_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    checks++; if (bus.EN_start !== 1'b0) begin errors++; $display("FAIL reset_en_start got %b want 0", bus.EN_start); end
    checks++; if (bus.EN_check !== 1'b0) begin errors++; $display("FAIL reset_en_check got %b want 0", bus.EN_check); end
    checks++; if (bus.start_sta_1 !== 11'h000) begin errors++; $display("FAIL reset_start_sta got %h want 000", bus.start_sta_1); end
    checks++; if (bus.check_std_1 !== 11'h000) begin errors++; $display("FAIL reset_check_std got %h want 000", bus.check_std_1); end
    checks++; if (bus.rsp_result !== 11'h000) begin errors++; $display("FAIL reset_rsp_result got %h want 000", bus.rsp_result); end
    checks++; if (bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_id_err got %b%b want 00", bus.rsp_id, bus.rsp_err); end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  // Both requesters always valid: grants must alternate starting with req0,
  // and successive accepts sit 5 cycles apart (4-cycle service + handshake bubble).
  task automatic test_round_robin();
    int   exp_id [4] = '{0, 1, 0, 1};
    int   gids [4];
    int   rids [4];
    int   gcyc [4];
    int   ng = 0;
    int   nr = 0;
    bit   both_seen = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.result = 11'h111; bus.check = 11'h222;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    for (int c = 0; c < 80 && nr < 4; c++) begin
      if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) both_seen = 1'b1;
      if (ng < 4 && (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1)) begin
        gids[ng] = (bus.req1_ready === 1'b1) ? 1 : 0;
        gcyc[ng] = c;
        ng++;
      end
      if (bus.rsp_valid === 1'b1) begin
        rids[nr] = int'(bus.rsp_id);
        nr++;
      end
      step();
      if (ng == 4) begin bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; end
    end
    checks++; if (both_seen) begin errors++; $display("FAIL rr_exclusive got both ready want one"); end
    checks++; if (ng != 4 || nr != 4) begin errors++; $display("FAIL rr_count got grants=%0d rsps=%0d want 4/4", ng, nr); end
    for (int i = 0; i < ng && i < 4; i++) begin
      checks++; if (gids[i] != exp_id[i]) begin errors++; $display("FAIL rr_grant[%0d] got %0d want %0d", i, gids[i], exp_id[i]); end
    end
    for (int i = 0; i < nr && i < 4; i++) begin
      checks++; if (rids[i] != exp_id[i]) begin errors++; $display("FAIL rr_rsp_id[%0d] got %0d want %0d", i, rids[i], exp_id[i]); end
    end
    for (int i = 0; i + 1 < ng; i++) begin
      checks++; if (gcyc[i+1] - gcyc[i] != 5) begin errors++; $display("FAIL rr_gap[%0d] got %0d want 5", i, gcyc[i+1] - gcyc[i]); end
    end
  endtask

  task automatic test_single();
    int lat, ns, nc; logic [W-1:0] s_sta, s_stb, s_key; bit to;
    bus.RDY_start = 1'b1; bus.RDY_result = 1'b1; bus.RDY_check = 1'b1;
    bus.result = 11'h008; bus.check = 11'h001; bus.rsp_ready = 1'b0;
    bus.req0_sta = 11'h005; bus.req0_stb = 11'h003; bus.req0_key = 11'h001;
    bus.req0_valid = 1'b1;
    #1;
    checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready got %b%b want 01", bus.req1_ready, bus.req0_ready); end
    step();
    bus.req0_valid = 1'b0;
    wait_rsp(1, 20, lat, ns, nc, s_sta, s_stb, s_key, to);
    checks++; if (to) begin errors++; $display("FAIL single_timeout got no rsp_valid want rsp_valid"); end
    checks++; if (lat != 4) begin errors++; $display("FAIL single_latency got %0d want 4", lat); end
    checks++; if (ns != 1 || nc != 1) begin errors++; $display("FAIL single_en_pulses got start=%0d check=%0d want 1/1", ns, nc); end
    checks++; if (s_sta !== 11'h005 || s_stb !== 11'h003 || s_key !== 11'h001) begin errors++; $display("FAIL single_operands got %h %h %h want 005 003 001", s_sta, s_stb, s_key); end
    checks++; if (bus.check_std_1 !== 11'h001) begin errors++; $display("FAIL single_check_std got %h want 001", bus.check_std_1); end
    checks++; if (bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL single_id_err got %b%b want 00", bus.rsp_id, bus.rsp_err); end
    checks++; if (bus.rsp_result !== 11'h008 || bus.rsp_check !== 11'h001) begin errors++; $display("FAIL single_rsp_data got %h %h want 008 001", bus.rsp_result, bus.rsp_check); end
    bus.rsp_ready = 1'b1;
    step();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_after_hs got %b want 0", bus.rsp_valid); end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_start_stall();
    int lat, ns, nc; logic [W-1:0] s_sta, s_stb, s_key; bit to;
    bus.RDY_start = 1'b0; bus.rsp_ready = 1'b0;
    bus.req1_sta = 11'h123; bus.req1_stb = 11'h456; bus.req1_key = 11'h0AA;
    bus.req1_valid = 1'b1;
    #1;
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL stall_accept got %b want 1", bus.req1_ready); end
    step();
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.EN_start !== 1'b0) begin errors++; $display("FAIL stall_en_low[%0d] got %b want 0", i, bus.EN_start); end
      step();
    end
    bus.RDY_start = 1'b1;
    wait_rsp(4, 20, lat, ns, nc, s_sta, s_stb, s_key, to);
    checks++; if (to) begin errors++; $display("FAIL stall_timeout got no rsp_valid want rsp_valid"); end
    checks++; if (lat != 7) begin errors++; $display("FAIL stall_latency got %0d want 7", lat); end
    checks++; if (ns != 1 || s_sta !== 11'h123 || s_stb !== 11'h456) begin errors++; $display("FAIL stall_start got n=%0d %h %h want 1 123 456", ns, s_sta, s_stb); end
    checks++; if (bus.rsp_id !== 1'b1 || bus.rsp_result !== 11'h008) begin errors++; $display("FAIL stall_rsp got id=%b res=%h want 1 008", bus.rsp_id, bus.rsp_result); end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int lat, ns, nc; logic [W-1:0] s_sta, s_stb, s_key; bit to;
    bus.RDY_result = 1'b0; bus.result = 11'h7FF; bus.check = 11'h7FF; bus.rsp_ready = 1'b0;
    bus.req0_sta = 11'h011; bus.req0_stb = 11'h022; bus.req0_key = 11'h033;
    bus.req0_valid = 1'b1;
    #1;
    step();
    bus.req0_valid = 1'b0;
    wait_rsp(1, 40, lat, ns, nc, s_sta, s_stb, s_key, to);
    checks++; if (to) begin errors++; $display("FAIL timeout_no_rsp got no rsp_valid want rsp_valid"); end
    checks++; if (lat != 18) begin errors++; $display("FAIL timeout_latency got %0d want 18", lat); end
    checks++; if (bus.rsp_err !== 1'b1) begin errors++; $display("FAIL timeout_err got %b want 1", bus.rsp_err); end
    checks++; if (bus.rsp_result !== 11'h000 || bus.rsp_check !== 11'h000) begin errors++; $display("FAIL timeout_data got %h %h want 000 000", bus.rsp_result, bus.rsp_check); end
    checks++; if (nc != 0) begin errors++; $display("FAIL timeout_en_check got %0d want 0", nc); end
    checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL timeout_id got %b want 0", bus.rsp_id); end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    bus.RDY_result = 1'b1;
  endtask

  task automatic test_rsp_backpressure();
    int lat, ns, nc; logic [W-1:0] s_sta, s_stb, s_key; bit to;
    bus.rsp_ready = 1'b0; bus.result = 11'h2A5; bus.check = 11'h15A;
    bus.req0_valid = 1'b1;
    #1;
    step();
    bus.req0_valid = 1'b0;
    wait_rsp(1, 20, lat, ns, nc, s_sta, s_stb, s_key, to);
    checks++; if (to || lat != 4) begin errors++; $display("FAIL bp_first_rsp got lat=%0d to=%b want 4 0", lat, to); end
    bus.result = 11'h000; bus.check = 11'h000;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", i, bus.rsp_valid); end
      checks++; if (bus.rsp_result !== 11'h2A5 || bus.rsp_check !== 11'h15A) begin errors++; $display("FAIL bp_data[%0d] got %h %h want 2a5 15a", i, bus.rsp_result, bus.rsp_check); end
      checks++; if (bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL bp_id_err[%0d] got %b%b want 00", i, bus.rsp_id, bus.rsp_err); end
      checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d] got %b%b want 00", i, bus.req1_ready, bus.req0_ready); end
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL bp_hs_cycle_ready got %b%b want 00", bus.req1_ready, bus.req0_ready); end
    step();
    checks++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin errors++; $display("FAIL bp_resume_ready got %b%b want 10", bus.req1_ready, bus.req0_ready); end
    step();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    wait_rsp(1, 20, lat, ns, nc, s_sta, s_stb, s_key, to);
    checks++; if (to || bus.rsp_id !== 1'b1) begin errors++; $display("FAIL bp_second_rsp got id=%b to=%b want 1 0", bus.rsp_id, to); end
    step();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat, ns, nc; logic [W-1:0] s_sta, s_stb, s_key; bit to;
    int stray = 0;
    bus.RDY_result = 1'b0; bus.rsp_ready = 1'b0;
    bus.req0_sta = 11'h0F0; bus.req0_stb = 11'h00F; bus.req0_key = 11'h0C3;
    bus.req0_valid = 1'b1;
    #1;
    step();
    bus.req0_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.EN_start !== 1'b0 || bus.EN_check !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got %b%b%b want 000", bus.rsp_valid, bus.EN_start, bus.EN_check); end
    checks++; if (bus.start_sta_1 !== 11'h000 || bus.start_stb_1 !== 11'h000 || bus.result_stc_1 !== 11'h000) begin errors++; $display("FAIL rstmid_operands got %h %h %h want 0 0 0", bus.start_sta_1, bus.start_stb_1, bus.result_stc_1); end
    checks++; if (bus.rsp_result !== 11'h000 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rstmid_rsp got %h %b want 000 0", bus.rsp_result, bus.rsp_err); end
    step();
    rst = 1'b0;
    bus.RDY_result = 1'b1; bus.result = 11'h321; bus.check = 11'h123; bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.rsp_valid === 1'b1 || bus.EN_start === 1'b1 || bus.EN_check === 1'b1) stray++;
      step();
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL rstmid_stale got %0d active cycles want 0", stray); end
    bus.rsp_ready = 1'b0;
    bus.req1_sta = 11'h0AB; bus.req1_stb = 11'h0CD; bus.req1_key = 11'h0EF;
    bus.req1_valid = 1'b1;
    #1;
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL rstmid_accept got %b want 1", bus.req1_ready); end
    step();
    bus.req1_valid = 1'b0;
    wait_rsp(1, 20, lat, ns, nc, s_sta, s_stb, s_key, to);
    checks++; if (to || lat != 4) begin errors++; $display("FAIL rstmid_latency got lat=%0d to=%b want 4 0", lat, to); end
    checks++; if (ns != 1 || s_sta !== 11'h0AB || s_key !== 11'h0EF) begin errors++; $display("FAIL rstmid_start got n=%0d %h %h want 1 0ab 0ef", ns, s_sta, s_key); end
    checks++; if (bus.rsp_id !== 1'b1 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rstmid_id_err got %b%b want 10", bus.rsp_id, bus.rsp_err); end
    checks++; if (bus.rsp_result !== 11'h321 || bus.rsp_check !== 11'h123) begin errors++; $display("FAIL rstmid_data got %h %h want 321 123", bus.rsp_result, bus.rsp_check); end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_start_stall();
    test_timeout();
    test_rsp_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
